// File: rtl/quadrature_pkg.sv
// Shared constants and the phase-transition decoder for the quadrature counter.
package quadrature_pkg;

   localparam logic [1:0] MODE_X1 = 2'b00;
   localparam logic [1:0] MODE_X2 = 2'b01;
   localparam logic [1:0] MODE_X4 = 2'b10;

   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_01 = 2'b01;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_10 = 2'b10;

   typedef enum logic [1:0] {
      EV_NONE    = 2'd0,
      EV_INC     = 2'd1,
      EV_DEC     = 2'd2,
      EV_ILLEGAL = 2'd3
   } event_e;

   // Classifies one {A,B} phase step; mode 2'b11 decodes as x4.
   function automatic event_e decode_event(input logic [1:0] prev,
                                           input logic [1:0] phase,
                                           input logic [1:0] mode);
      event_e result;
      logic   fwd;
      logic   a_edge;
      fwd = (prev == PH_00 && phase == PH_01) ||
            (prev == PH_01 && phase == PH_11) ||
            (prev == PH_11 && phase == PH_10) ||
            (prev == PH_10 && phase == PH_00);
      a_edge = prev[1] ^ phase[1];
      result = EV_NONE;
      if (prev == phase) begin
         result = EV_NONE;
      end else if ((prev ^ phase) == 2'b11) begin
         result = EV_ILLEGAL;
      end else begin
         case (mode)
            MODE_X1: begin
               if (prev == PH_01 && phase == PH_11)      result = EV_INC;
               else if (prev == PH_00 && phase == PH_10) result = EV_DEC;
            end
            MODE_X2: begin
               if (a_edge) result = fwd ? EV_INC : EV_DEC;
            end
            default: result = fwd ? EV_INC : EV_DEC;
         endcase
      end
      return result;
   endfunction

endpackage

// File: rtl/quadrature_filter.sv
// Synchroniser plus debounce filter for one encoder line.
module quadrature_filter #(
   parameter int   SYNC_STAGES   = 2,
   parameter int   FILTER_CYCLES = 4,
   parameter logic REST_STATE    = 1'b1
) (
   input  logic clk,
   input  logic resetn,
   input  logic raw,
   output logic level
);

   localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0]          count;
   logic                   s;

   assign s = sync[SYNC_STAGES-1];

   // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync  <= {SYNC_STAGES{REST_STATE}};
         level <= REST_STATE;
         count <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], raw};
         if (s == level) begin
            count <= '0;
         end else if (count == LAST) begin
            level <= s;
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/quadrature_counter.sv
// Quadrature encoder decoder with x1/x2/x4 modes, wrap/clamp counting and load.
module quadrature_counter
   import quadrature_pkg::*;
#(
   parameter int   WIDTH         = 8,
   parameter logic REST_STATE    = 1'b1,
   parameter int   SYNC_STAGES   = 2,
   parameter int   FILTER_CYCLES = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             a_in,
   input  logic             b_in,
   input  logic [1:0]       mode,
   input  logic             saturate,
   input  logic [WIDTH-1:0] min_value,
   input  logic [WIDTH-1:0] max_value,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] value,
   output logic             step,
   output logic             dir,
   output logic             error
);

   logic             fa;
   logic             fb;
   logic [1:0]       phase;
   logic [1:0]       prev;
   event_e           evt;
   logic             limits_ok;
   logic [WIDTH-1:0] next_value;

   quadrature_filter #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .REST_STATE   (REST_STATE)
   ) u_filter_a (
      .clk   (clk),
      .resetn(resetn),
      .raw   (a_in),
      .level (fa)
   );

   quadrature_filter #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .REST_STATE   (REST_STATE)
   ) u_filter_b (
      .clk   (clk),
      .resetn(resetn),
      .raw   (b_in),
      .level (fb)
   );

   assign phase = {fa, fb};
   assign evt   = decode_event(prev, phase, mode);

   // Inverted limits block both directions in clamp mode.
   // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latch).
   always_comb begin
      limits_ok  = (min_value <= max_value);
      next_value = value;
      if (load) begin
         next_value = load_value;
      end else if (evt == EV_INC) begin
         if (!saturate || (limits_ok && value < max_value)) next_value = value + 1'b1;
      end else if (evt == EV_DEC) begin
         if (!saturate || (limits_ok && value > min_value)) next_value = value - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         prev  <= {REST_STATE, REST_STATE};
         value <= '0;
         step  <= 1'b0;
         dir   <= 1'b0;
         error <= 1'b0;
      end else begin
         prev  <= phase;
         value <= next_value;
         step  <= (evt == EV_INC) || (evt == EV_DEC);
         error <= (evt == EV_ILLEGAL);
         if (evt == EV_INC || evt == EV_DEC) dir <= (evt == EV_INC);
      end
   end

endmodule

// File: tb/tb_quadrature_counter.sv
// Scoreboard bench for quadrature_counter: events predicted at the pins, checked at the outputs.
module tb_quadrature_counter;
   import quadrature_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         resetn;
   logic         a_in, b_in, saturate, load;
   logic [1:0]   mode;
   logic [W-1:0] min_value, max_value, load_value, value;
   logic         step, dir, error;

   typedef struct {
      logic         err;
      logic         dir;
      logic [W-1:0] val;
      int           cyc;
   } exp_t;

   exp_t         sb[$];
   exp_t         mon_r;
   int           cyc = 0;
   int           n_vec = 0;
   int           n_err = 0;
   logic [1:0]   cur;
   logic [W-1:0] exp_val;

   quadrature_counter #(
      .WIDTH(W), .REST_STATE(1'b1), .SYNC_STAGES(2), .FILTER_CYCLES(4)
   ) dut (
      .clk(clk), .resetn(resetn), .a_in(a_in), .b_in(b_in), .mode(mode),
      .saturate(saturate), .min_value(min_value), .max_value(max_value),
      .load(load), .load_value(load_value), .value(value), .step(step),
      .dir(dir), .error(error)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Position in the forward cycle 00 -> 01 -> 11 -> 10.
   function automatic int pos(input logic [1:0] p);
      case (p)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   // 0 none, 1 increment, -1 decrement, 2 illegal.
   function automatic int model_evt(input logic [1:0] old, input logic [1:0] nw, input logic [1:0] m);
      int   d;
      logic counts;
      d = (pos(nw) - pos(old) + 4) % 4;
      if (d == 0) return 0;
      if (d == 2) return 2;
      case (m)
         2'b00:   counts = (d == 1 && nw == 2'b11) || (d == 3 && nw == 2'b10);
         2'b01:   counts = (d == 1) ? (nw[1] == nw[0]) : (nw[1] != nw[0]);
         default: counts = 1'b1;
      endcase
      return counts ? ((d == 1) ? 1 : -1) : 0;
   endfunction

   // Drive a new pin level, held for 'hold' sampling edges; optionally load in the event cycle.
   task automatic set_pins(input logic a, input logic b, input int hold,
                           input logic do_load = 1'b0, input logic [W-1:0] lval = '0);
      int   e;
      exp_t r;
      @(posedge clk);
      #2;
      a_in = a;
      b_in = b;
      e    = model_evt(cur, {a, b}, mode);
      cur  = {a, b};
      if (e == 1) begin
         if (!saturate) exp_val = exp_val + 1'b1;
         else if (min_value <= max_value && exp_val < max_value) exp_val = exp_val + 1'b1;
      end else if (e == -1) begin
         if (!saturate) exp_val = exp_val - 1'b1;
         else if (min_value <= max_value && exp_val > min_value) exp_val = exp_val - 1'b1;
      end
      if (do_load) exp_val = lval;
      if (e != 0) begin
         r = '{(e == 2), (e == 1), exp_val, cyc + 7};
         sb.push_back(r);
      end
      if (do_load) begin
         repeat (6) @(posedge clk);
         #2;
         load_value = lval;
         load       = 1'b1;
         @(posedge clk);
         #2;
         load = 1'b0;
         repeat (hold - 8) @(posedge clk);
      end else begin
         repeat (hold - 1) @(posedge clk);
      end
   endtask

   task automatic do_load(input logic [W-1:0] v);
      @(posedge clk);
      #2;
      load_value = v;
      load       = 1'b1;
      @(posedge clk);
      #2;
      load    = 1'b0;
      exp_val = v;
      check("load_value", 32'(value), 32'(v));
   endtask

   always @(negedge clk) begin
      if (resetn === 1'b1 && (step === 1'b1 || error === 1'b1)) begin
         if (sb.size() == 0) begin
            check("unexpected_event", 32'({step, error}), 32'd0);
         end else begin
            mon_r = sb.pop_front();
            check("evt_kind", 32'(error), 32'(mon_r.err));
            if (!mon_r.err) check("evt_dir", 32'(dir), 32'(mon_r.dir));
            check("evt_value", 32'(value), 32'(mon_r.val));
            check("evt_latency", 32'(cyc), 32'(mon_r.cyc));
         end
      end
   end

   initial begin
      resetn = 1'b0;
      a_in = 1'b1; b_in = 1'b1;
      mode = MODE_X1; saturate = 1'b0;
      min_value = '0; max_value = '1;
      load = 1'b0; load_value = '0;
      cur = 2'b11; exp_val = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_value", 32'(value), 32'd0);
      check("rst_step", 32'(step), 32'd0);
      check("rst_dir", 32'(dir), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      @(posedge clk);
      #2 resetn = 1'b1;

      // x1 wrap: three forward cycles, one count each.
      repeat (3) begin
         set_pins(1'b1, 1'b0, 10);
         set_pins(1'b0, 1'b0, 10);
         set_pins(1'b0, 1'b1, 10);
         set_pins(1'b1, 1'b1, 10);
      end
      check("x1_value", 32'(value), 32'd3);
      check("x1_pending", 32'(sb.size()), 32'd0);

      // Walk to phase 00 without x1 counts, then x4 reverse and forward.
      set_pins(1'b1, 1'b0, 10);
      set_pins(1'b0, 1'b0, 10);
      check("x1_no_count", 32'(value), 32'd3);
      do_load(8'd0);
      mode = MODE_X4;
      set_pins(1'b1, 1'b0, 10);
      check("x4_wrap_down", 32'(value), 32'd255);
      check("x4_dir_down", 32'(dir), 32'd0);
      set_pins(1'b0, 1'b0, 10);
      set_pins(1'b0, 1'b1, 10);
      set_pins(1'b1, 1'b1, 10);
      set_pins(1'b1, 1'b0, 10);
      set_pins(1'b0, 1'b0, 10);
      check("x4_fwd5", 32'(value), 32'd4);

      // x2 clamp to [10,20].
      mode = MODE_X2; saturate = 1'b1;
      min_value = 8'd10; max_value = 8'd20;
      do_load(8'd19);
      repeat (2) begin
         set_pins(1'b0, 1'b1, 10);
         set_pins(1'b1, 1'b1, 10);
         set_pins(1'b1, 1'b0, 10);
         set_pins(1'b0, 1'b0, 10);
      end
      check("x2_clamp_hi", 32'(value), 32'd20);
      set_pins(1'b1, 1'b0, 10);
      check("x2_rev", 32'(value), 32'd19);

      // Debounce: 3-cycle glitch rejected, 4-cycle pulse accepted.
      mode = MODE_X4; saturate = 1'b0;
      min_value = '0; max_value = '1;
      set_pins(1'b0, 1'b0, 10);
      set_pins(1'b0, 1'b1, 10);
      check("pre_glitch", 32'(value), 32'd21);
      @(posedge clk);
      #2 a_in = 1'b1;
      repeat (3) @(posedge clk);
      #2 a_in = 1'b0;
      repeat (12) @(posedge clk);
      check("glitch_reject", 32'(value), 32'd21);
      set_pins(1'b1, 1'b1, 4);
      set_pins(1'b0, 1'b1, 10);
      repeat (4) @(posedge clk);
      check("pulse4_accept", 32'(value), 32'd21);
      check("pulse4_pending", 32'(sb.size()), 32'd0);

      // Double-bit transition flags an error, then normal counting resumes.
      set_pins(1'b0, 1'b0, 10);
      set_pins(1'b1, 1'b1, 10);
      check("illegal_hold", 32'(value), 32'd20);
      set_pins(1'b1, 1'b0, 10);
      check("after_illegal", 32'(value), 32'd21);

      // Load wins over a same-cycle increment.
      set_pins(1'b0, 1'b0, 10, 1'b1, 8'h55);
      check("load_vs_inc", 32'(value), 32'h55);

      // Reset mid-rotation.
      @(posedge clk);
      #2 b_in = 1'b1;
      repeat (3) @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      check("async_rst_value", 32'(value), 32'd0);
      a_in = 1'b1; b_in = 1'b1;
      cur = 2'b11; exp_val = '0;
      repeat (3) @(posedge clk);
      #2 resetn = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("post_rst_value", 32'(value), 32'd0);
      check("post_rst_dir", 32'(dir), 32'd0);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/quadrature_counter.md
Name: quadrature_counter

Overview:
Parametrised quadrature rotary-encoder decoder and position counter for the stopwatch front panel. Generalises the single-mode A-rising-edge counter.
- Adds input synchronisers and a debounce filter.
- Adds x1/x2/x4 decode modes, wrap or clamp-to-limits counting, and synchronous load.
- Adds step/direction/error event outputs for the AXI register block.

Parameters:
WIDTH, 8, counter width in bits
REST_STATE, 1, idle level of A/B lines; reset value of all input-path flops
SYNC_STAGES, 2, synchroniser depth per input (>=2)
FILTER_CYCLES, 4, consecutive stable cycles required before a new A/B level is accepted (>=1)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
a_in  in  1  encoder channel A, asynchronous
b_in  in  1  encoder channel B, asynchronous
mode  in  2  00=x1, 01=x2, 10=x4, 11=x4
saturate  in  1  1=clamp to [min_value,max_value], 0=wrap modulo 2^WIDTH
min_value  in  WIDTH  lower clamp limit, unsigned
max_value  in  WIDTH  upper clamp limit, unsigned
load  in  1  synchronous load strobe
load_value  in  WIDTH  value written on load
value  out  WIDTH  position count
step  out  1  one-cycle pulse per decoded count event
dir  out  1  direction of last event, 1=increment; holds between events
error  out  1  one-cycle pulse on illegal (double-bit) transition

Behaviour:
- Reset (async, resetn=0):
  - sync chains and filtered A/B = {REST_STATE,REST_STATE}; filter counters = 0.
  - value = 0; step = 0; dir = 0; error = 0.
  - Asserting reset mid-rotation clears everything immediately; no event is generated on release.
- Filter, per channel, on the synchronised input s versus the filtered level f:
  - if s==f, counter <= 0;
  - else if counter==FILTER_CYCLES-1, f <= s and counter <= 0;
  - else counter++.
- Phase = {fA,fB}. The register prev holds the phase from the previous cycle.
- Forward (increment) sequence: 00 -> 01 -> 11 -> 10 -> 00. Reverse is the opposite order.
- Count event qualification by mode:
  - x1: only 01->11 (+1) and 00->10 (-1). This is identical to the legacy single-mode counter.
  - x2: every A edge counts. 01->11 = +1, 10->00 = +1, 00->10 = -1, 11->01 = -1.
  - x4: every legal single-bit transition counts.
- Illegal transition (both bits differ between prev and phase): error=1 for one cycle, no count, prev still updates.
- Latency: a stable pin change reaches value/step/dir exactly SYNC_STAGES+FILTER_CYCLES+1 clk edges after the first edge that samples it.
- Counting, on a qualified event:
  - step=1 and dir=sign, both registered in the same cycle as the value update.
  - Wrap mode (saturate=0): value +/-1 modulo 2^WIDTH; min_value and max_value are ignored.
  - Clamp mode (saturate=1): increment only if value<max_value; decrement only if value>min_value; otherwise value holds.
  - step/dir still pulse when the count is clamped.
  - A value outside the limits (e.g. after load) only moves toward the range.
- Load: value <= load_value the next edge; load has priority over a same-cycle count. step/dir/error still report that cycle's event.
- mode/saturate/limits may change at any time. They apply to the next event only; phase tracking is not disturbed.
- min_value > max_value in clamp mode: both directions blocked; value holds.

Decomposition:
- Package quadrature_pkg:
  - mode constants MODE_X1=2'b00, MODE_X2=2'b01, MODE_X4=2'b10;
  - phase encoding constants PH_00, PH_01, PH_11, PH_10;
  - function returning event (none/inc/dec/illegal) from (prev, phase, mode).
- Sub-module quadrature_filter: SYNC_STAGES synchroniser plus debounce counter for one line, parametrised by SYNC_STAGES, FILTER_CYCLES and REST_STATE. Instantiated once for A and once for B.

Test Plan:
1. WIDTH=8, x1, wrap; 3 full forward cycles, each level held 10 cycles -> value=3, exactly 3 step pulses with dir=1; first update exactly 7 edges after the first pin change.
2. x4, wrap, from value 0; one reverse step (00->10) -> value=255, dir=0. Then 5 forward steps -> value=4.
3. x2, clamp, min=10, max=20; load 19, then 4 forward x2 events -> value 20,20,20 after the first reaches 20; 4 step pulses. Then 1 reverse event -> 19.
4. Glitch A high for 3 cycles (< FILTER_CYCLES) -> no step, value unchanged. Hold A high for 4 cycles -> accepted, x4 count +1.
5. Force A and B to toggle in the same cycle (00->11) -> error pulses 1 cycle, value unchanged. The next legal 11->10 counts +1 in x4.
6. load=1 in the same cycle as a qualified increment, load_value=0x55 -> value=0x55, step=1. Then resetn pulsed low mid-rotation -> value=0 asynchronously, no step after release.
